palette_loader: RTL and testbench

- Owns a 64x15 single-port palette RAM holding a user palette downloaded from the host.
- Two requesters share the one RAM port:
  - the video pixel lookup, which has priority;
  - the host byte-stream loader.
- Packs 192-byte RGB888 .pal streams into BGR555 entries.
- Muxes the custom palette against the built-in palette pixel in front of the video mixer.

---
 rtl/palette_loader_if.sv | 31 +++
 rtl/palette_loader.sv | 181 ++++++++++++++++++
 tb/tb_palette_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_loader_if.sv
// Bus bundle for palette_loader: the video lookup signals and the host
// byte-stream loader handshake. The host/video side drives through
// master; the palette block sits on slave.
interface palette_loader_if;
  logic        pix_ce;
  logic [5:0]  color;
  logic [14:0] builtin_pixel;
  logic        pal_sel;
  logic [14:0] pixel;

  logic        ld_start;
  logic        ld_wr;
  logic [10:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_done;
  logic        ld_wait;
  logic        custom_valid;
  logic        ld_error;

  modport master (
    output pix_ce, color, builtin_pixel, pal_sel,
    output ld_start, ld_wr, ld_addr, ld_data, ld_done,
    input  pixel, ld_wait, custom_valid, ld_error
  );

  modport slave (
    input  pix_ce, color, builtin_pixel, pal_sel,
    input  ld_start, ld_wr, ld_addr, ld_data, ld_done,
    output pixel, ld_wait, custom_valid, ld_error
  );
endinterface

// File: rtl/palette_loader.sv
// palette_loader: a 64x15 single-port palette RAM shared between the video
// pixel lookup (always wins the port) and a host loader that packs an
// RGB888 .pal byte stream into BGR555 entries. The pixel fed to the mixer
// is the custom entry only once a complete, error-free palette is loaded.
module palette_loader #(
  parameter int ENTRIES    = 64,
  parameter int LOAD_BYTES = 192
) (
  input logic             clk,
  input logic             reset_n,
  palette_loader_if.slave bus
);

  localparam int AW = $clog2(ENTRIES);
  localparam int CW = $clog2(LOAD_BYTES + 1);
  localparam logic [CW-1:0] LOAD_BYTES_C = CW'(LOAD_BYTES);
  localparam logic [CW-1:0] BYTE_ONE     = CW'(1);
  localparam logic [AW-1:0] ENTRY_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, next_state;

  // Loader datapath
  logic [CW-1:0] byte_cnt;
  logic [1:0]    comp_cnt;
  logic [AW-1:0] entry_cnt;
  logic [4:0]    r_slot;
  logic [4:0]    g_slot;
  logic [14:0]   pend_word;
  logic [AW-1:0] pend_idx;
  logic          pend_valid;
  logic          custom_valid_q;
  logic          ld_error_q;

  // Per-cycle decisions from the FSM
  logic ld_wait_c;
  logic accept;
  logic overrun;
  logic finalize;
  logic ram_wr;

  // RAM and video pipeline
  logic [14:0] mem [ENTRIES];
  logic [14:0] ram_q;
  logic        vid_d1;
  logic [14:0] builtin_d1;
  logic        use_custom_d1;
  logic [14:0] pixel_q;

  // The low three bits of each colour byte are dropped when packing to 5 bits.
  logic unused_ld_data;
  assign unused_ld_data = ^bus.ld_data[2:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state plus the byte accept/drop/finalize decisions for this cycle.
  always_comb begin
    next_state = state;
    ld_wait_c  = 1'b0;
    accept     = 1'b0;
    overrun    = 1'b0;
    finalize   = 1'b0;
    ram_wr     = pend_valid && !bus.pix_ce;
    case (state)
      IDLE: begin
        if (bus.ld_start) next_state = LOAD;
      end
      LOAD: begin
        ld_wait_c = pend_valid && (comp_cnt == 2'd2);
        if (bus.ld_start) begin
          next_state = LOAD;
        end else begin
          if (bus.ld_wr) begin
            if (ld_wait_c)                   overrun = 1'b1;
            else if (byte_cnt < LOAD_BYTES_C) accept  = 1'b1;
          end
          if (bus.ld_done) next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.ld_start) begin
          next_state = LOAD;
        end else if (!pend_valid) begin
          finalize   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte packing, pending-write slot and the sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt       <= '0;
      comp_cnt       <= 2'd0;
      entry_cnt      <= '0;
      r_slot         <= 5'd0;
      g_slot         <= 5'd0;
      pend_word      <= 15'd0;
      pend_idx       <= '0;
      pend_valid     <= 1'b0;
      custom_valid_q <= 1'b0;
      ld_error_q     <= 1'b0;
    end else begin
      if (ram_wr) pend_valid <= 1'b0;
      if (bus.ld_start) begin
        byte_cnt       <= '0;
        comp_cnt       <= 2'd0;
        entry_cnt      <= '0;
        custom_valid_q <= 1'b0;
        ld_error_q     <= 1'b0;
      end else begin
        if (accept) begin
          if (bus.ld_addr != 11'(byte_cnt)) ld_error_q <= 1'b1;
          byte_cnt <= byte_cnt + BYTE_ONE;
          case (comp_cnt)
            2'd0: begin
              r_slot   <= bus.ld_data[7:3];
              comp_cnt <= 2'd1;
            end
            2'd1: begin
              g_slot   <= bus.ld_data[7:3];
              comp_cnt <= 2'd2;
            end
            default: begin
              pend_word  <= {bus.ld_data[7:3], g_slot, r_slot};
              pend_idx   <= entry_cnt;
              pend_valid <= 1'b1;
              entry_cnt  <= entry_cnt + ENTRY_ONE;
              comp_cnt   <= 2'd0;
            end
          endcase
        end
        if (overrun) ld_error_q <= 1'b1;
        if (finalize) begin
          if (byte_cnt == LOAD_BYTES_C && !ld_error_q) custom_valid_q <= 1'b1;
          else                                         ld_error_q     <= 1'b1;
        end
      end
    end
  end

  // Single RAM port: a video read takes it, otherwise the pending write drains.
  always_ff @(posedge clk) begin
    if (bus.pix_ce)      ram_q <= mem[bus.color[AW-1:0]];
    else if (pend_valid) mem[pend_idx] <= pend_word;
  end

  // Video pipeline: capture selection with the request, pick on the q cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_d1        <= 1'b0;
      builtin_d1    <= 15'd0;
      use_custom_d1 <= 1'b0;
      pixel_q       <= 15'd0;
    end else begin
      vid_d1 <= bus.pix_ce;
      if (bus.pix_ce) begin
        builtin_d1    <= bus.builtin_pixel;
        use_custom_d1 <= bus.pal_sel && custom_valid_q;
      end
      if (vid_d1) pixel_q <= use_custom_d1 ? ram_q : builtin_d1;
    end
  end

  assign bus.pixel        = pixel_q;
  assign bus.ld_wait      = ld_wait_c;
  assign bus.custom_valid = custom_valid_q;
  assign bus.ld_error     = ld_error_q;

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: reset, full loads with and without
// video contention, address errors, short/long files, overrun and restarts.
module tb_palette_loader;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  palette_loader_if bus ();

  palette_loader #(.ENTRIES(64), .LOAD_BYTES(192)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_left = 0;
  bit pix_auto = 1'b0;
  bit wait_seen = 1'b0;
  logic [14:0] rd_pix;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs are updated 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (hold_left > 0) begin
      hold_left--;
      bus.pix_ce = (hold_left > 0);
    end else if (pix_auto) begin
      bus.pix_ce = ((cyc % 8) == 0);
      bus.color  = 6'(cyc);
    end
  endtask

  // Byte value of the .pal stream for a given pattern and byte index.
  function automatic logic [7:0] pat(input int mode, input int idx);
    int k;
    int c;
    k = idx / 3;
    c = idx % 3;
    if (idx >= 192) return 8'(idx) ^ 8'h5A;
    if (mode == 0) begin
      if (c == 0) return 8'(8 * k);
      if (c == 1) return 8'(255 - k);
      return 8'h80;
    end
    if (c == 0) return 8'(4 * k + 1);
    if (c == 1) return 8'(k) ^ 8'hA5;
    return 8'(255 - 2 * k);
  endfunction

  // Expected BGR555 entry: top five bits of each colour byte.
  function automatic logic [14:0] exp_entry(input int mode, input int k);
    logic [7:0] r, g, b;
    r = pat(mode, 3 * k);
    g = pat(mode, 3 * k + 1);
    b = pat(mode, 3 * k + 2);
    return {b[7:3], g[7:3], r[7:3]};
  endfunction

  // Send one byte, holding off while the block asks to wait.
  task automatic applyStimulus(input int addr, input logic [7:0] data);
    int guard;
    guard = 0;
    while (bus.ld_wait === 1'b1 && guard < 200) begin
      wait_seen = 1'b1;
      step();
      guard++;
    end
    if (guard >= 200) checkOutput("ld_wait_timeout", 32'd1, 32'd0);
    bus.ld_wr   = 1'b1;
    bus.ld_addr = 11'(addr);
    bus.ld_data = data;
    step();
    bus.ld_wr = 1'b0;
  endtask

  task automatic pulse_start();
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
  endtask

  task automatic pulse_done();
    bus.ld_done = 1'b1;
    step();
    bus.ld_done = 1'b0;
  endtask

  // Full download of nbytes; bad_idx presents that byte with a wrong address.
  task automatic load_file(input int mode, input int nbytes, input int bad_idx);
    pulse_start();
    for (int i = 0; i < nbytes; i++)
      applyStimulus((i == bad_idx) ? i + 1 : i, pat(mode, i));
    pulse_done();
  endtask

  // Wait a bounded number of cycles for custom_valid to rise.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.custom_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(bus.custom_valid), 32'd1);
  endtask

  // One video lookup; returns the pixel two cycles after the request.
  task automatic read_entry(input int idx, input logic [14:0] builtin, input logic sel,
                            output logic [14:0] pix);
    bus.pal_sel       = sel;
    bus.color         = 6'(idx);
    bus.builtin_pixel = builtin;
    bus.pix_ce        = 1'b1;
    step();
    bus.pix_ce = 1'b0;
    step();
    pix = bus.pixel;
  endtask

  task automatic verify_ram(input int mode, input string tag);
    logic [14:0] e;
    for (int k = 0; k < 64; k++) begin
      e = exp_entry(mode, k);
      read_entry(k, ~e, 1'b1, rd_pix);
      checkOutput($sformatf("%s[%0d]", tag, k), 32'(rd_pix), 32'(e));
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    reset_n           = 1'b0;
    bus.pix_ce        = 1'b0;
    bus.color         = 6'd0;
    bus.builtin_pixel = 15'h1234;
    bus.pal_sel       = 1'b0;
    bus.ld_start      = 1'b0;
    bus.ld_wr         = 1'b0;
    bus.ld_addr       = 11'd0;
    bus.ld_data       = 8'd0;
    bus.ld_done       = 1'b0;

    // Reset held with pix_ce toggling.
    for (int i = 0; i < 6; i++) begin
      bus.pix_ce = ~bus.pix_ce;
      step();
    end
    bus.pix_ce = 1'b0;
    checkOutput("rst_pixel", 32'(bus.pixel), 32'd0);
    checkOutput("rst_valid", 32'(bus.custom_valid), 32'd0);
    checkOutput("rst_wait", 32'(bus.ld_wait), 32'd0);
    checkOutput("rst_error", 32'(bus.ld_error), 32'd0);
    reset_n = 1'b1;
    step();
    read_entry(3, 15'h1234, 1'b0, rd_pix);
    checkOutput("post_rst_builtin", 32'(rd_pix), 32'h1234);
    read_entry(3, 15'h2222, 1'b1, rd_pix);
    checkOutput("no_custom_builtin", 32'(rd_pix), 32'h2222);

    // Full load with a video read every 8 cycles.
    pix_auto = 1'b1;
    load_file(0, 192, -1);
    pix_auto   = 1'b0;
    bus.pix_ce = 1'b0;
    wait_valid("full_valid");
    checkOutput("full_error", 32'(bus.ld_error), 32'd0);
    read_entry(5, 15'h1111, 1'b1, rd_pix);
    checkOutput("full_entry5", 32'(rd_pix), 32'h43E5);
    step();
    step();
    checkOutput("pixel_hold", 32'(bus.pixel), 32'h43E5);
    read_entry(5, 15'h1111, 1'b0, rd_pix);
    checkOutput("palsel0_builtin", 32'(rd_pix), 32'h1111);
    verify_ram(0, "ram0");

    // Contention: pix_ce held high for 20 cycles mid-load.
    wait_seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 192; i++) begin
      if (i == 30) begin
        bus.pix_ce = 1'b1;
        bus.color  = 6'd9;
        hold_left  = 20;
      end
      applyStimulus(i, pat(1, i));
    end
    pulse_done();
    checkOutput("contention_wait_seen", 32'(wait_seen), 32'd1);
    wait_valid("contention_valid");
    checkOutput("contention_error", 32'(bus.ld_error), 32'd0);
    verify_ram(1, "ram1");

    // Address mismatch on byte 10.
    load_file(0, 192, 10);
    checkOutput("addr_error", 32'(bus.ld_error), 32'd1);
    for (int i = 0; i < 8; i++) step();
    checkOutput("addr_valid", 32'(bus.custom_valid), 32'd0);
    read_entry(5, 15'h0ABC, 1'b1, rd_pix);
    checkOutput("addr_builtin", 32'(rd_pix), 32'h0ABC);

    // Short file.
    load_file(0, 150, -1);
    for (int i = 0; i < 8; i++) step();
    checkOutput("short_error", 32'(bus.ld_error), 32'd1);
    checkOutput("short_valid", 32'(bus.custom_valid), 32'd0);

    // Long file: bytes past 192 are ignored.
    load_file(1, 1536, -1);
    wait_valid("long_valid");
    checkOutput("long_error", 32'(bus.ld_error), 32'd0);
    read_entry(63, 15'h0, 1'b1, rd_pix);
    checkOutput("long_entry63", 32'(rd_pix), 32'(exp_entry(1, 63)));
    read_entry(0, 15'h0, 1'b1, rd_pix);
    checkOutput("long_entry0", 32'(rd_pix), 32'(exp_entry(1, 0)));

    // Overrun while ld_wait is high.
    pulse_start();
    checkOutput("restart_clears_valid", 32'(bus.custom_valid), 32'd0);
    bus.pix_ce = 1'b1;
    hold_left  = 20;
    for (int i = 0; i < 5; i++) applyStimulus(i, pat(0, i));
    checkOutput("overrun_wait", 32'(bus.ld_wait), 32'd1);
    bus.ld_wr   = 1'b1;
    bus.ld_addr = 11'd5;
    bus.ld_data = pat(0, 5);
    step();
    bus.ld_wr = 1'b0;
    checkOutput("overrun_error", 32'(bus.ld_error), 32'd1);
    checkOutput("overrun_no_advance", 32'(bus.ld_wait), 32'd1);
    for (int i = 0; i < 20; i++) step();
    pulse_start();
    checkOutput("restart_clears_error", 32'(bus.ld_error), 32'd0);
    checkOutput("restart_valid_low", 32'(bus.custom_valid), 32'd0);

    // ld_start with ld_wr: the byte is dropped, the load starts clean.
    bus.ld_start = 1'b1;
    bus.ld_wr    = 1'b1;
    bus.ld_addr  = 11'd0;
    bus.ld_data  = 8'hFF;
    step();
    bus.ld_start = 1'b0;
    bus.ld_wr    = 1'b0;
    for (int i = 0; i < 192; i++) applyStimulus(i, pat(0, i));
    pulse_done();
    wait_valid("start_wr_valid");
    checkOutput("start_wr_error", 32'(bus.ld_error), 32'd0);
    read_entry(0, 15'h7FFF, 1'b1, rd_pix);
    checkOutput("start_wr_entry0", 32'(rd_pix), 32'(exp_entry(0, 0)));

    // Reset mid-load.
    pulse_start();
    for (int i = 0; i < 30; i++) applyStimulus(i, pat(1, i));
    reset_n = 1'b0;
    #2;
    checkOutput("midrst_valid", 32'(bus.custom_valid), 32'd0);
    checkOutput("midrst_error", 32'(bus.ld_error), 32'd0);
    checkOutput("midrst_wait", 32'(bus.ld_wait), 32'd0);
    checkOutput("midrst_pixel", 32'(bus.pixel), 32'd0);
    reset_n = 1'b1;
    step();
    bus.ld_wr   = 1'b1;
    bus.ld_addr = 11'd7;
    bus.ld_data = 8'h33;
    for (int i = 0; i < 3; i++) step();
    bus.ld_wr = 1'b0;
    checkOutput("idle_ignores_wr", 32'(bus.ld_error), 32'd0);
    pulse_done();
    for (int i = 0; i < 4; i++) step();
    checkOutput("idle_done_valid", 32'(bus.custom_valid), 32'd0);
    checkOutput("idle_done_error", 32'(bus.ld_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
